// File: rtl/bus_pkg.sv
// Shared definitions for the 64-bit cache-line bus.
// Used by the memory responder and reusable by dcache/icache/arbiter.
package bus_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int BUS_TAG_WIDTH = 13;
    localparam int TAG_OP_WRITE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        RD_WAIT,
        RD_RESP
    } bus_state_t;

    function automatic logic [31:0] line_base(
        input logic [31:0] word_idx,
        input int unsigned beats
    );
        return word_idx & ~(beats - 1);
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// Single-port word array behind the bus responder.
// Synchronous write, combinational read, no reset.
module bus_mem_array #(
    parameter int WORDS = 4096,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory responder for the 64-bit cache-line bus (write bursts, timed read bursts).
// Define BUSRESP_CRITICAL_WORD_FIRST_EN to return the requested word first on reads.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = bus_pkg::BUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = bus_pkg::BUS_TAG_WIDTH,
    parameter int BEATS          = 8,
    parameter int MEM_WORDS      = 4096,
    parameter int RD_LATENCY     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack,
    output logic                      busy
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = $clog2(BEATS);
    localparam int CW = $clog2(RD_LATENCY) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    bus_state_t               state;
    logic [AW-1:0]            base;
    logic [BW-1:0]            beat;
    logic [CW-1:0]            lat_cnt;
    logic [BUS_TAG_WIDTH-1:0] tag_q;
`ifdef BUSRESP_CRITICAL_WORD_FIRST_EN
    logic [BW-1:0]            crit;
`endif

    logic [AW-1:0]             addr_idx;
    logic [AW-1:0]             new_base;
    logic [AW-1:0]             mem_addr;
    logic                      mem_we;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;
    logic [BW-1:0]             rd_beat;
    logic [BW-1:0]             rd_off;
    logic                      accept;

    assign addr_idx = bus_req[3 +: AW];
    assign new_base = AW'(line_base(32'(addr_idx), BEATS));
    // The cycle after an ack is a gap so the initiator can advance its word.
    assign accept   = bus_reqcyc && !bus_reqack;
    assign busy     = (state != IDLE);

    // Address the beat that will be presented next, so its data is ready
    // in the register at the same time bus_respcyc rises or advances.
    always_comb begin
        rd_beat  = '0;
        rd_off   = '0;
        mem_we   = 1'b0;
        mem_addr = '0;
        if (state == RD_RESP) begin
            rd_beat = beat + BW'(1);
        end
`ifdef BUSRESP_CRITICAL_WORD_FIRST_EN
        rd_off = crit + rd_beat;
`else
        rd_off = rd_beat;
`endif
        mem_we = (state == WR_DATA) && accept;
        if (mem_we) begin
            mem_addr = base + AW'(beat);
        end else begin
            mem_addr = base + AW'(rd_off);
        end
    end

    bus_mem_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (BUS_DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus_req),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base        <= '0;
            beat        <= '0;
            lat_cnt     <= '0;
            tag_q       <= '0;
`ifdef BUSRESP_CRITICAL_WORD_FIRST_EN
            crit        <= '0;
`endif
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            bus_reqack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        base       <= new_base;
                        tag_q      <= bus_reqtag;
                        beat       <= '0;
                        bus_reqack <= 1'b1;
`ifdef BUSRESP_CRITICAL_WORD_FIRST_EN
                        crit       <= addr_idx[BW-1:0];
`endif
                        if (bus_reqtag[TAG_OP_WRITE_BIT]) begin
                            state <= WR_DATA;
                        end else begin
                            lat_cnt <= CW'(RD_LATENCY - 1);
                            state   <= RD_WAIT;
                        end
                    end
                end
                WR_DATA: begin
                    if (accept) begin
                        bus_reqack <= 1'b1;
                        beat       <= beat + BW'(1);
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        state       <= RD_RESP;
                        beat        <= '0;
                        bus_respcyc <= 1'b1;
                        bus_resp    <= mem_rdata;
                        bus_resptag <= tag_q;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                RD_RESP: begin
                    if (bus_respack) begin
                        if (beat == LAST_BEAT) begin
                            bus_respcyc <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            beat     <= beat + BW'(1);
                            bus_resp <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: random bursts against a line model.
// Follows BUSRESP_CRITICAL_WORD_FIRST_EN for the expected read order.
module tb_bus_mem_responder;

    localparam int DW        = 64;
    localparam int TW        = 13;
    localparam int BEATS     = 8;
    localparam int MEM_WORDS = 4096;
    localparam int RD_LAT    = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bus_reqcyc = 1'b0;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    bus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .BEATS          (BEATS),
        .MEM_WORDS      (MEM_WORDS),
        .RD_LATENCY     (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_count = 0;
    int exp_first = -1;
    int ack_mode = 0;
    int pat = 0;

    logic [DW-1:0] mdl [MEM_WORDS];
    logic [DW-1:0] wbuf [BEATS];
    exp_t exp_q[$];
    logic [DW-1:0] wr_addrs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    task automatic fail_msg(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // respack patterns: 0 = always high, 1 = 1,0,0 repeating, 2 = random
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: bus_respack = 1'b1;
            1: begin
                bus_respack = (pat % 3 == 0);
                pat++;
            end
            default: bus_respack = 1'($urandom_range(0, 1));
        endcase
    end

    logic          prev_reqack = 1'b0;
    logic          prev_respcyc = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_resp = '0;
    logic [TW-1:0] prev_tag = '0;

    always @(negedge clk) begin
        exp_t e;
        if (bus_reqack === 1'b1) begin
            chk("reqack_gap", 64'(prev_reqack), 64'd0);
            ack_count++;
        end
        if (bus_respcyc === 1'b1) begin
            if (!prev_respcyc) begin
                if (exp_first < 0) begin
                    fail_msg("unexpected_resp");
                end else begin
                    chk("first_beat_latency", 64'(cyc), 64'(exp_first));
                    exp_first = -1;
                end
            end
            if (prev_hold) begin
                chk("hold_data", bus_resp, prev_resp);
                chk("hold_tag", 64'(bus_resptag), 64'(prev_tag));
            end
            if (bus_respack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_msg("extra_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus_resp, e.d);
                    chk("beat_tag", 64'(bus_resptag), 64'(e.t));
                end
            end
        end
        prev_reqack  = (bus_reqack === 1'b1);
        prev_respcyc = (bus_respcyc === 1'b1);
        prev_hold    = (bus_respcyc === 1'b1) && (bus_respack !== 1'b1);
        prev_resp    = bus_resp;
        prev_tag     = bus_resptag;
    end

    function automatic int word_of(input logic [DW-1:0] addr);
        return int'((addr >> 3) % MEM_WORDS);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) fail_msg("idle_timeout");
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic [TW-1:0] t,
                             output int ack_cyc);
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b1;
        bus_req    = w;
        bus_reqtag = t;
        ack_cyc    = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_reqack === 1'b1) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) fail_msg("reqack_timeout");
    endtask

    task automatic do_write(input logic [DW-1:0] addr, input logic [TW-1:0] tag);
        int a0;
        int ac;
        int base;
        logic [TW-1:0] wt;
        wt = tag | TW'(1);
        wait_idle();
        a0 = ack_count;
        send_word(addr, wt, ac);
        for (int k = 0; k < BEATS; k++) send_word(wbuf[k], wt, ac);
        chk("busy_after_write", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b0;
        chk("write_ack_count", 64'(ack_count - a0), 64'(BEATS + 1));
        base = word_of(addr) - word_of(addr) % BEATS;
        for (int k = 0; k < BEATS; k++) mdl[base + k] = wbuf[k];
        wr_addrs.push_back(addr);
    endtask

    task automatic start_read(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                              input int mode);
        int ac;
        int w;
        int base;
        int crit;
        int off;
        logic [TW-1:0] rt;
        exp_t e;
        rt = tag & ~TW'(1);
        wait_idle();
        ack_mode = mode;
        w    = word_of(addr);
        base = w - w % BEATS;
        crit = w % BEATS;
        for (int k = 0; k < BEATS; k++) begin
`ifdef BUSRESP_CRITICAL_WORD_FIRST_EN
            off = (crit + k) % BEATS;
`else
            off = k;
`endif
            e.d = mdl[base + off];
            e.t = rt;
            exp_q.push_back(e);
        end
        send_word(addr, rt, ac);
        if (ac >= 0) exp_first = ac + RD_LAT;
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b0;
    endtask

    task automatic finish_read();
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            fail_msg("read_timeout");
            exp_q.delete();
        end
    endtask

    initial begin
        logic [DW-1:0] ra;
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_reqack", 64'(bus_reqack), 64'd0);
        chk("reset_respcyc", 64'(bus_respcyc), 64'd0);
        chk("reset_resp", bus_resp, 64'd0);
        chk("reset_resptag", 64'(bus_resptag), 64'd0);
        reset = 1'b0;

        for (int k = 0; k < BEATS; k++) wbuf[k] = 64'h10 + 64'(k);
        do_write(64'h1000, 13'h0001);

        start_read(64'h1000, 13'h0A0, 0);
        finish_read();
        start_read(64'h1000, 13'h0A0, 1);
        finish_read();
        start_read(64'h1018, 13'h0A0, 0);
        finish_read();

        for (int k = 0; k < BEATS; k++) wbuf[k] = 64'hA11A_0000 + 64'(k);
        do_write(64'h0, 13'h0003);
        start_read(64'(MEM_WORDS * 8), 13'h0040, 1);
        finish_read();

        start_read(64'h1000, 13'h0A0, 0);
        n = 0;
        while (!(bus_respcyc === 1'b1 && exp_q.size() == BEATS - 2) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 100) fail_msg("third_beat_timeout");
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("reset_mid_respcyc", 64'(bus_respcyc), 64'd0);
        chk("reset_mid_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        exp_first = -1;
        start_read(64'h1000, 13'h0A0, 2);
        finish_read();

        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < BEATS; k++) wbuf[k] = {$urandom(), $urandom()};
            do_write({$urandom(), $urandom()}, 13'($urandom()));
            ra = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            ra = (ra & ~64'h3F) | (64'($urandom_range(0, BEATS - 1)) << 3)
                 | 64'($urandom_range(0, 7));
            ra = ra ^ ({$urandom(), $urandom()} << 15);
            start_read(ra, 13'($urandom()), int'($urandom_range(0, 2)));
            finish_read();
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Responder end of the 64-bit cache-line bus that the dcache/icache initiators drive.
- Accepts a line address plus a tag, then either absorbs a write burst or returns a read burst after a programmable latency.
- Backed by an internal word-addressed array.
- Serves as the memory model behind the bus arbiter for block-level and core-level simulation.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp and of one beat.
- BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag.
- BEATS, 8, beats per line (line = BEATS*8 bytes = 64 B).
- MEM_WORDS, 4096, depth of the backing array in 64-bit words; must be a power of two.
- RD_LATENCY, 4, cycles from address acceptance to the first read beat; must be >= 1.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- bus_reqcyc, input, 1, initiator holds a valid request word.
- bus_req, input, BUS_DATA_WIDTH, byte address (address phase) or write data (write data phase).
- bus_reqtag, input, BUS_TAG_WIDTH, request tag; bit 0 is the op: 1 = write, 0 = read.
- bus_reqack, output, 1, one-cycle pulse: the current request word is consumed.
- bus_respcyc, output, 1, read beat valid.
- bus_resp, output, BUS_DATA_WIDTH, read beat data.
- bus_resptag, output, BUS_TAG_WIDTH, tag of the read being returned.
- bus_respack, input, 1, initiator consumed the current read beat.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset values: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, busy=0, state=IDLE, all counters 0.
- The backing array is never reset.
- Reset mid-burst aborts the burst immediately. Write beats already stored remain in the array.
- Addressing:
  - Word index = addr[3 +: log2(MEM_WORDS)]; higher address bits are ignored, so addresses alias modulo the array size.
  - Line base = word index with its low log2(BEATS) bits cleared.
  - Beat k targets line base + k.
  - Address bits [2:0] are ignored.
- State machine: IDLE, WR_DATA, RD_WAIT, RD_RESP.
- IDLE:
  - When bus_reqcyc=1: latch the address and tag, and pulse bus_reqack on the next cycle.
  - If tag[0]=1, go to WR_DATA; otherwise load the latency counter with RD_LATENCY-1 and go to RD_WAIT.
- Ack gap: bus_reqack is never high on two consecutive cycles. After each ack, the responder ignores bus_reqcyc for that cycle so the initiator can advance its word.
- WR_DATA:
  - On each cycle with bus_reqcyc=1 and no ack issued in the previous cycle: write bus_req to array[base+beat], pulse bus_reqack on the next cycle, and increment beat.
  - After beat BEATS-1 is written, return to IDLE.
  - Write burst completes in 2*BEATS cycles minimum.
  - If bus_reqcyc drops mid-burst, wait indefinitely.
- RD_WAIT:
  - Decrement the counter each cycle; at 0, go to RD_RESP with beat=0.
  - First bus_respcyc is asserted exactly RD_LATENCY+1 cycles after the cycle in which the address was sampled.
- RD_RESP:
  - Drive bus_respcyc=1, bus_resp=array[base+order(beat)], bus_resptag=latched tag.
  - Data and tag are held stable while bus_respack=0.
  - On a cycle with bus_respcyc=1 and bus_respack=1: advance beat. The next beat is presented on the following cycle, so back-to-back acks give one beat per cycle.
  - After BEATS-1 is acknowledged: bus_respcyc=0 on the next cycle, return to IDLE.
- order(beat) = beat, unless the optional feature below is enabled.
- A new request can be accepted the cycle after returning to IDLE. Requests arriving while not in IDLE are not acked.
- Array read is combinational from the registered index (registered output); the first beat's data must be valid on the first cycle that bus_respcyc is high.

Optional Feature:
- Macro: BUSRESP_CRITICAL_WORD_FIRST_EN.
- Defined: order(beat) = (crit + beat) mod BEATS, where crit = latched word index low log2(BEATS) bits. The read returns the requested word first and wraps within the line. Writes are unaffected and stay sequential from the base.
- Undefined: order(beat) = beat; reads always start at the line base.

Decomposition:
- Package bus_pkg:
  - typedef enum of FSM states.
  - localparam TAG_OP_WRITE_BIT = 0.
  - helper function line_base().
  - shared BUS_DATA_WIDTH/BUS_TAG_WIDTH defaults, for reuse by dcache/icache/arbiter.
- One sub-module: bus_mem_array (single port, write-enable, combinational read, MEM_WORDS x BUS_DATA_WIDTH). The FSM stays in bus_mem_responder.

Test Plan:
- Reset then write to addr 0x1000: reqcyc with tag 0x0001 then beats 0x10..0x17 -> 9 reqack pulses, never consecutive, busy drops afterwards; array words 0x200..0x207 = 0x10..0x17.
- Read of line 0x1000, tag 0x0A0 (bit0=0), respack held high -> respcyc first high exactly RD_LATENCY+1=5 cycles after the address sample; 8 consecutive beats 0x10..0x17; resptag=0x0A0 on every beat.
- Same read with respack toggling 1,0,0,1... -> each beat is held unchanged while respack=0; no beat skipped or duplicated.
- Read of addr 0x1018 with the feature enabled -> beat order 0x13,0x14,...,0x17,0x10,0x11,0x12. With the feature disabled -> 0x10..0x17.
- Alias check: write line at 0x0, then read addr MEM_WORDS*8 -> same data returned.
- Reset asserted on the 3rd read beat -> respcyc=0 and busy=0 the next cycle; a subsequent read returns the full, correct line.
